// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data RAM (synchronous read, 1-cycle latency)
// between the ARM core (requester 0, "cpu") and an auxiliary master
// (requester 1, "aux": loader, display, debug).
//
// Writes complete in the grant cycle. Reads take two cycles: the grant
// cycle issues the RAM read, and the following RESP cycle returns
// mem_rdata to the owner. The CPU wins ties unless aux has already lost
// AUX_MAX_WAIT consecutive cycles, in which case aux is forced through.
//
// Handshakes:
//   cpu: cpu_req/cpu_we/cpu_addr/cpu_wdata are held stable while
//        cpu_stall=1; the access completes in the first cycle with
//        cpu_req=1 and cpu_stall=0 (read data on cpu_rdata that cycle).
//   aux: aux_req/aux_we/aux_addr/aux_wdata are held stable until aux_ack;
//        aux_ack is a one-cycle completion pulse (read data on aux_rdata
//        that cycle), and aux drops or changes its request the next cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cpu_*               core side (byte addresses, ReadData, stall)
//   aux_*               auxiliary master side (byte addresses, ack)
//   mem_*               data RAM side (word address)
//   dbg_state           FSM state: 0=IDLE, 1=RESP_CPU, 2=RESP_AUX
//
// The core's PC-advance logic must gate on cpu_stall.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int AUX_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [31:0]       aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESP_CPU = 2'd1,
        RESP_AUX = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT = 8'(AUX_MAX_WAIT);

    state_t            state;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] aux_rdata_q;

    logic              in_idle;
    logic              aux_forced;
    logic              grant_cpu;
    logic              grant_aux;
    logic              resp_cpu;
    logic              resp_aux;
    logic [ADDR_W-1:0] cpu_word;
    logic [ADDR_W-1:0] aux_word;

    // Byte offset and bits above the RAM depth are dropped: addresses wrap.
    assign cpu_word = cpu_addr[ADDR_W+1:2];
    assign aux_word = aux_addr[ADDR_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                aux_addr[31:ADDR_W+2], aux_addr[1:0]};

    // Grant decision. Reset masks every grant and every RESP cycle, so a
    // write presented together with reset never reaches the RAM and a
    // pending read response is abandoned.
    always_comb begin
        in_idle    = !reset && (state == IDLE);
        aux_forced = (wait_cnt >= MAX_WAIT);
        grant_aux  = in_idle && aux_req && (!cpu_req || aux_forced);
        grant_cpu  = in_idle && cpu_req && !grant_aux;
        resp_cpu   = !reset && (state == RESP_CPU);
        resp_aux   = !reset && (state == RESP_AUX);
    end

    always_comb begin
        mem_en    = grant_cpu || grant_aux;
        mem_we    = (grant_cpu && cpu_we) || (grant_aux && aux_we);
        mem_addr  = grant_aux ? aux_word : cpu_word;
        mem_wdata = grant_aux ? aux_wdata : cpu_wdata;

        // The CPU is released only by its own write grant or its RESP cycle.
        cpu_stall = !reset && cpu_req && !((grant_cpu && cpu_we) || resp_cpu);
        aux_ack   = (grant_aux && aux_we) || resp_aux;

        cpu_rdata = resp_cpu ? mem_rdata : cpu_rdata_q;
        aux_rdata = resp_aux ? mem_rdata : aux_rdata_q;
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cpu && !cpu_we) begin
                        state <= RESP_CPU;
                    end else if (grant_aux && !aux_we) begin
                        state <= RESP_AUX;
                    end
                end
                default: state <= IDLE;
            endcase

            // The RESP_AUX cycle is aux being served, not aux losing, so
            // it does not count towards the starvation limit.
            if (!aux_req || grant_aux || (state == RESP_AUX)) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (resp_cpu) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (resp_aux) begin
                aux_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed steps followed by a randomized phase. A behavioural RAM sits on
// the mem_* port; a separate reference memory (ref_mem) is updated only when
// the bench sees an access complete on the cpu/aux handshake, and every read
// completion is compared against it. Latency bounds for both requesters are
// checked from the arbitration rules (CPU priority, aux forced after
// AUX_MAX_WAIT lost cycles).
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              cpu_req, cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              aux_req, aux_we;
    logic [31:0]       aux_addr;
    logic [DATA_W-1:0] aux_wdata, aux_rdata;
    logic              aux_ack;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [1:0]        dbg_state;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUX_MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_rdata(aux_rdata), .aux_ack(aux_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Environment RAM: synchronous read, one cycle latency.
    logic [DATA_W-1:0] ram [0:1023] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] ref_mem [0:1023] = '{default: '0};
    logic [DATA_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] word_of(input logic [31:0] a);
        return a[11:2];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] data);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    endtask

    task automatic aux_drive(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] data);
        aux_req = req; aux_we = we; aux_addr = addr; aux_wdata = data;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // random-phase driver state
    logic        c_busy, c_we, a_busy, a_we, a_cool;
    logic [31:0] c_addr, c_data, a_addr, a_data;
    int          c_wait, a_wait;

    initial begin
        // ---- reset, with a CPU write presented during reset ----
        reset = 1'b1;
        cpu_drive(1'b1, 1'b1, 32'h80, 32'hBAD0_0001);
        aux_drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        sample();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_aux_ack", aux_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_aux_rdata", aux_rdata, 0);
        check("rst_state", dbg_state, 0);

        // ---- CPU write 0xDEADBEEF to 0x40 ----
        tick();
        reset = 1'b0;
        cpu_drive(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        sample();
        check("cw_mem_en", mem_en, 1);
        check("cw_mem_we", mem_we, 1);
        check("cw_mem_addr", mem_addr, 32'h010);
        check("cw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("cw_stall", cpu_stall, 0);
        ref_mem[word_of(32'h40)] = 32'hDEAD_BEEF;

        // ---- CPU read 0x40: two cycles ----
        tick();
        cpu_drive(1'b1, 1'b0, 32'h40, 32'h0);
        sample();
        check("cr_grant_stall", cpu_stall, 1);
        check("cr_grant_en", mem_en, 1);
        check("cr_grant_we", mem_we, 0);
        check("cr_grant_addr", mem_addr, 32'h010);
        tick();
        sample();
        check("cr_resp_stall", cpu_stall, 0);
        check("cr_resp_data", cpu_rdata, ref_mem[word_of(32'h40)]);
        check("cr_resp_en", mem_en, 0);
        tick();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        sample();
        check("cr_hold_data", cpu_rdata, 32'hDEAD_BEEF);

        // ---- aux write 0x12345678 to 0x1004 (wraps to word 1) ----
        tick();
        aux_drive(1'b1, 1'b1, 32'h1004, 32'h1234_5678);
        sample();
        check("aw_mem_en", mem_en, 1);
        check("aw_mem_we", mem_we, 1);
        check("aw_mem_addr", mem_addr, 32'h001);
        check("aw_ack", aux_ack, 1);
        ref_mem[word_of(32'h1004)] = 32'h1234_5678;
        tick();
        aux_drive(1'b0, 1'b0, 32'h0, 32'h0);
        cpu_drive(1'b1, 1'b0, 32'h4, 32'h0);
        sample();
        check("aw_cr_stall", cpu_stall, 1);
        check("aw_ack_low", aux_ack, 0);
        tick();
        sample();
        check("aw_cr_data", cpu_rdata, 32'h1234_5678);

        // ---- aux read, CPU raises a write during RESP_AUX ----
        tick();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        aux_drive(1'b1, 1'b0, 32'h1004, 32'h0);
        sample();
        check("ar_grant_ack", aux_ack, 0);
        check("ar_grant_en", mem_en, 1);
        check("ar_grant_addr", mem_addr, 32'h001);
        tick();
        cpu_drive(1'b1, 1'b1, 32'h8, 32'hCAFE_F00D);
        sample();
        check("ar_resp_ack", aux_ack, 1);
        check("ar_resp_data", aux_rdata, ref_mem[1]);
        check("ar_resp_cpu_stall", cpu_stall, 1);
        check("ar_resp_en", mem_en, 0);
        tick();
        aux_drive(1'b0, 1'b0, 32'h0, 32'h0);
        sample();
        check("ar_cw_stall", cpu_stall, 0);
        check("ar_cw_en", mem_en, 1);
        check("ar_cw_we", mem_we, 1);
        check("ar_cw_addr", mem_addr, 32'h002);
        check("ar_cw_ack", aux_ack, 0);
        ref_mem[2] = 32'hCAFE_F00D;
        tick();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        sample();
        check("ar_hold_data", aux_rdata, 32'h1234_5678);

        // ---- steady contention, two rounds from an idle start ----
        for (int r = 0; r < 2; r++) begin
            tick();
            cpu_drive(1'b1, 1'b0, 32'h8, 32'h0);
            aux_drive(1'b1, 1'b0, 32'h1004, 32'h0);
            for (int k = 0; k <= MAX_WAIT; k++) begin
                sample();
                check($sformatf("ct%0d_aux_grant_%0d", r, k),
                      32'(mem_en && (mem_addr == 10'd1)), 32'(k == MAX_WAIT));
                check($sformatf("ct%0d_stall_%0d", r, k), cpu_stall, 32'((k % 2) == 0));
                if ((k % 2) == 1) check($sformatf("ct%0d_cdata_%0d", r, k), cpu_rdata, ref_mem[2]);
                tick();
            end
            sample();
            check($sformatf("ct%0d_aux_ack", r), aux_ack, 1);
            check($sformatf("ct%0d_aux_data", r), aux_rdata, ref_mem[1]);
            check($sformatf("ct%0d_resp_stall", r), cpu_stall, 1);
            tick();
            aux_drive(1'b0, 1'b0, 32'h0, 32'h0);
            sample();
            check($sformatf("ct%0d_after_ack", r), aux_ack, 0);
            check($sformatf("ct%0d_cpu_regrant", r), mem_en, 1);
            tick();
            sample();
            check($sformatf("ct%0d_cpu_done", r), cpu_stall, 0);
            tick();
            cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
            sample();
            check($sformatf("ct%0d_idle_en", r), mem_en, 0);
        end

        // ---- reset during RESP_CPU, write suppressed ----
        tick();
        cpu_drive(1'b1, 1'b0, 32'h40, 32'h0);
        sample();
        check("rr_grant_stall", cpu_stall, 1);
        tick();
        reset = 1'b1;
        cpu_drive(1'b1, 1'b1, 32'h40, 32'h0BAD_BAD0);
        aux_drive(1'b1, 1'b0, 32'h1004, 32'h0);
        sample();
        check("rr_mem_en", mem_en, 0);
        check("rr_mem_we", mem_we, 0);
        check("rr_stall", cpu_stall, 0);
        check("rr_ack", aux_ack, 0);
        tick();
        reset = 1'b0;
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        aux_drive(1'b0, 1'b0, 32'h0, 32'h0);
        sample();
        check("rr_state", dbg_state, 0);
        check("rr_cpu_rdata", cpu_rdata, 0);
        check("rr_aux_rdata", aux_rdata, 0);
        check("rr_ack_after", aux_ack, 0);
        tick();
        cpu_drive(1'b1, 1'b0, 32'h40, 32'h0);
        sample();
        tick();
        sample();
        check("rr_suppressed", cpu_rdata, ref_mem[word_of(32'h40)]);

        // ---- randomized traffic against the reference memory ----
        tick();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        c_busy = 0; a_busy = 0; a_cool = 0; c_wait = 0; a_wait = 0;
        c_we = 0; a_we = 0; c_addr = 0; a_addr = 0; c_data = 0; a_data = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (!c_busy) begin
                if (cyc < 640 && $urandom_range(0, 3) != 0) begin
                    c_busy = 1; c_wait = 0;
                    c_we   = 1'($urandom_range(0, 1));
                    c_addr = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2)
                             | 32'($urandom_range(0, 3));
                    c_data = $urandom();
                    cpu_drive(1'b1, c_we, c_addr, c_data);
                end else begin
                    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
            if (!a_busy) begin
                if (!a_cool && cyc < 640 && $urandom_range(0, 2) == 0) begin
                    a_busy = 1; a_wait = 0;
                    a_we   = 1'($urandom_range(0, 1));
                    a_addr = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2)
                             | 32'($urandom_range(0, 3));
                    a_data = $urandom();
                    aux_drive(1'b1, a_we, a_addr, a_data);
                end else begin
                    aux_drive(1'b0, 1'b0, 32'h0, 32'h0);
                end
                a_cool = 0;
            end
            sample();
            if (c_busy) begin
                if (!cpu_stall) begin
                    if (c_we) begin
                        ref_mem[word_of(c_addr)] = c_data;
                    end else begin
                        exp_q.push_back(ref_mem[word_of(c_addr)]);
                        check("rnd_cpu_rdata", cpu_rdata, exp_q.pop_front());
                    end
                    check("rnd_cpu_latency", 32'(c_wait <= 3), 1);
                    c_busy = 0;
                end else begin
                    c_wait++;
                end
            end
            if (a_busy) begin
                if (aux_ack) begin
                    if (a_we) begin
                        ref_mem[word_of(a_addr)] = a_data;
                    end else begin
                        exp_q.push_back(ref_mem[word_of(a_addr)]);
                        check("rnd_aux_rdata", aux_rdata, exp_q.pop_front());
                    end
                    check("rnd_aux_latency", 32'(a_wait <= MAX_WAIT + 2), 1);
                    a_busy = 0;
                    a_cool = 1;
                end else begin
                    a_wait++;
                end
            end
            tick();
        end
        check("rnd_cpu_drained", 32'(c_busy), 0);
        check("rnd_aux_drained", 32'(a_busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
